// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: two-digit multiplexed 7-segment driver.
// Shows a held 8-bit hex value on a common-segment pair of digits, one
// nibble per slot. Each slot opens with a short blanking window to avoid
// ghosting while the digit select changes.
// Optional feature: define SEG7_LZ_BLANK_EN to blank a leading zero on the
// left digit. Without the macro the left digit shows '0' as usual.
module seg7_mux_driver #(
    parameter int REFRESH_DIV = 6000,
    parameter int BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] val_in,
    input  logic       val_valid,
    output logic [7:0] seg_out,
    output logic       slot_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [6:0]    SEG_OFF   = 7'b1111111;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    logic [7:0]    held_q, held_d;
    logic [7:0]    disp_q, disp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    state_t        state_q, state_d;
    logic          wrap_q, wrap_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick_q, tick_d;
    logic          wrap;
    logic [3:0]    nibble;
    logic [6:0]    code;

    // Segment patterns, order {a,b,c,d,e,f,g}, 0 lights the segment.
    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'b0000001;
            4'h1: c = 7'b1001111;
            4'h2: c = 7'b0010010;
            4'h3: c = 7'b0000110;
            4'h4: c = 7'b1001100;
            4'h5: c = 7'b0100100;
            4'h6: c = 7'b0100000;
            4'h7: c = 7'b0001111;
            4'h8: c = 7'b0000000;
            4'h9: c = 7'b0000100;
            4'hA: c = 7'b0001000;
            4'hB: c = 7'b1100000;
            4'hC: c = 7'b0110001;
            4'hD: c = 7'b1000010;
            4'hE: c = 7'b0110000;
            default: c = 7'b0111000;
        endcase
        return c;
    endfunction

    // Slot sequencing: counter, select, blank/show phase and the value
    // latch. The displayed value only moves on a slot wrap, and a valid on
    // the wrap cycle itself goes straight through to the new slot.
    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        held_d  = val_valid ? val_in : held_q;
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        sel_d   = wrap ? ~sel_q : sel_q;
        disp_d  = wrap ? held_d : disp_q;
        wrap_d  = wrap;
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_d == BLANK_END) state_d = ST_SHOW;
            ST_SHOW:  if (wrap) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
    end

    // Output decode from the current slot state; registered one clock later.
    // The tick follows a wrap, so the partial slot started by reset release
    // does not produce one.
    always_comb begin
        nibble = sel_q ? disp_q[3:0] : disp_q[7:4];
        code   = seg_lut(nibble);
`ifdef SEG7_LZ_BLANK_EN
        if (!sel_q && (disp_q[7:4] == 4'h0)) code = SEG_OFF;
`endif
        seg_d  = (state_q == ST_SHOW) ? {code, sel_q} : {SEG_OFF, sel_q};
        tick_d = wrap_q;
    end

    // State and output registers; reset leaves both digits dark on the right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q  <= 8'h00;
            disp_q  <= 8'h00;
            cnt_q   <= '0;
            sel_q   <= 1'b1;
            state_q <= ST_BLANK;
            wrap_q  <= 1'b0;
            seg_q   <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            held_q  <= held_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign seg_out   = seg_q;
    assign slot_tick = tick_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Testbench for seg7_mux_driver. A small instance (8-cycle slots, 2 blanking
// cycles) is walked slot by slot against hand-computed patterns; a default
// instance checks the slot rate over 24000 cycles. Expectations follow
// SEG7_LZ_BLANK_EN when the bench is built with it.
module tb_seg7_mux_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] val_in;
    logic       val_valid;
    logic [7:0] seg_out;
    logic       slot_tick;
    logic [7:0] segOutBig;
    logic       slotTickBig;

    int   assertCount = 0;
    int   failCount   = 0;
    logic expSel;

    always #5 clk = ~clk;

    seg7_mux_driver #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst(rst), .val_in(val_in), .val_valid(val_valid),
        .seg_out(seg_out), .slot_tick(slot_tick)
    );

    seg7_mux_driver dutBig (
        .clk(clk), .rst(rst), .val_in(8'h00), .val_valid(1'b0),
        .seg_out(segOutBig), .slot_tick(slotTickBig)
    );

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, actual, expected);
        end
    endtask

    // Presents a value for the next rising edge; callers drop val_valid after it.
    task automatic applyStimulus(input logic [7:0] v);
        val_in    = v;
        val_valid = 1'b1;
    endtask

    function automatic logic [6:0] segCode(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'b0000001;  4'h1: c = 7'b1001111;
            4'h2: c = 7'b0010010;  4'h3: c = 7'b0000110;
            4'h4: c = 7'b1001100;  4'h5: c = 7'b0100100;
            4'h6: c = 7'b0100000;  4'h7: c = 7'b0001111;
            4'h8: c = 7'b0000000;  4'h9: c = 7'b0000100;
            4'hA: c = 7'b0001000;  4'hB: c = 7'b1100000;
            4'hC: c = 7'b0110001;  4'hD: c = 7'b1000010;
            4'hE: c = 7'b0110000;  default: c = 7'b0111000;
        endcase
        return c;
    endfunction

    // Expected seg_out at position k of a slot showing value d with select s.
    function automatic logic [7:0] expSeg(input logic [7:0] d, input logic s, input int k);
        logic [3:0] n;
        logic [6:0] c;
        n = s ? d[3:0] : d[7:4];
        c = segCode(n);
`ifdef SEG7_LZ_BLANK_EN
        if (!s && (d[7:4] == 4'h0)) c = 7'b1111111;
`endif
        return (k < BLANK) ? {7'b1111111, s} : {c, s};
    endfunction

    // Walks one slot starting on its tick sample; optionally loads a value
    // at position loadAt (position 6 is the wrap cycle). Ends on the next tick.
    task automatic runSlot(input logic [7:0] d, input int loadAt, input logic [7:0] loadVal, input string tag);
        checkOutput($sformatf("%s_seg0", tag), seg_out, expSeg(d, expSel, 0));
        if (loadAt == 0) applyStimulus(loadVal);
        for (int k = 1; k < DIV; k++) begin
            @(posedge clk); #1;
            val_valid = 1'b0;
            checkOutput($sformatf("%s_seg%0d", tag, k), seg_out, expSeg(d, expSel, k));
            checkOutput($sformatf("%s_tick%0d", tag, k), {7'h00, slot_tick}, 8'h00);
            if (k == loadAt) applyStimulus(loadVal);
        end
        @(posedge clk); #1;
        val_valid = 1'b0;
        checkOutput($sformatf("%s_boundary", tag), {7'h00, slot_tick}, 8'h01);
        expSel = ~expSel;
    endtask

    initial begin
        int tickEdge;
        int bigTicks;
        logic bigSel;

        rst       = 1'b1;
        val_in    = 8'h00;
        val_valid = 1'b0;
        expSel    = 1'b1;

        // Reset held for three edges: dark display, no tick.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("rst_seg%0d", i), seg_out, 8'hFF);
            checkOutput($sformatf("rst_tick%0d", i), {7'h00, slot_tick}, 8'h00);
        end

        // Release; the first edge loads counter state 0 into the output
        // stage and the first tick lands DIV edges after that one.
        @(negedge clk);
        rst = 1'b0;
        tickEdge = 0;
        for (int i = 1; i <= 40 && tickEdge == 0; i++) begin
            @(posedge clk); #1;
            if (i == 1) checkOutput("post_rst_blank", seg_out, 8'hFF);
            if (i == 3) checkOutput("post_rst_right0", seg_out, 8'h03);
            if (slot_tick) tickEdge = i;
        end
        checkOutput("first_tick_latency", 8'(tickEdge - 1), 8'(DIV));
        expSel = 1'b0;

        runSlot(8'h00, 3, 8'h3A, "s1_left00");
        runSlot(8'h3A, -1, 8'h00, "s2_right3A");
        runSlot(8'h3A, 3, 8'h12, "s3_left3A");
        runSlot(8'h12, 3, 8'h34, "s4_right12_midload");
        runSlot(8'h34, 6, 8'hF0, "s5_left34_wrapload");
        runSlot(8'hF0, 7, 8'h07, "s6_rightF0");
        runSlot(8'hF0, -1, 8'h00, "s7_leftF0");
        runSlot(8'h07, -1, 8'h00, "s8_right07");
        runSlot(8'h07, -1, 8'h00, "s9_left07");

        // Asynchronous reset in the middle of a cycle, then a fresh start.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_seg", seg_out, 8'hFF);
        checkOutput("async_rst_tick", {7'h00, slot_tick}, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("async_rst_hold", seg_out, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("rerelease_seg%0d", i), seg_out, (i < 3) ? 8'hFF : 8'h03);
        end

        // Default instance: four ticks in any 24000-cycle window, select
        // alternating left/right starting with left after reset.
        repeat (97) @(posedge clk);
        bigTicks = 0;
        bigSel   = 1'b1;
        for (int i = 0; i < 24000; i++) begin
            @(posedge clk); #1;
            if (slotTickBig) begin
                bigTicks++;
                bigSel = ~bigSel;
                checkOutput($sformatf("big_tick%0d_seg", bigTicks), segOutBig, {7'b1111111, bigSel});
            end
        end
        checkOutput("big_tick_count", 8'(bigTicks), 8'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 6000: clk cycles per digit slot (2 kHz slot rate at 12 MHz); legal range 4..2^20.
REQ-002 SHALL have parameter BLANK_CYC, default 16: blanking cycles at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port val_in, input, 8: two-digit hex value; [7:4] is the left digit, [3:0] is the right digit.
REQ-006 SHALL have port val_valid, input, 1: qualifies val_in for one cycle.
REQ-007 SHALL have port seg_out, output, 8: {a,b,c,d,e,f,g,S}; a-g active-low (0=on); S is digit select (1=right, 0=left).
REQ-008 SHALL have port slot_tick, output, 1: one-cycle pulse on the cycle the displayed digit changes.

Function
REQ-009 SHALL capture val_in into a held register on each clk edge with val_valid=1, and SHALL retain the held value otherwise.
REQ-010 SHALL show a newly captured value from the next slot boundary only, so no slot displays a mix of old and new nibbles mid-slot.
REQ-011 SHALL run a slot counter 0..REFRESH_DIV-1 that wraps to 0, and SHALL toggle the digit select on the wrap.
REQ-012 SHALL have a two-state FSM: BLANK (counter < BLANK_CYC) and SHOW (otherwise); BLANK->SHOW at counter==BLANK_CYC; SHOW->BLANK at wrap.
REQ-013 SHALL drive seg_out[7:1]=7'b1111111 in BLANK, with seg_out[0] already at the new digit select.
REQ-014 SHALL drive the 7-segment code of the selected nibble in SHOW: right (S=1) uses [3:0], left (S=0) uses [7:4].
REQ-015 SHALL use these codes (abcdefg) for 0-F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-016 SHALL register seg_out: latency from a counter state to the matching seg_out value is exactly 1 clk.
REQ-017 SHALL assert slot_tick for exactly one cycle, aligned with the first BLANK cycle of each slot.
REQ-018 SHALL latch the newest value when val_valid is asserted on the wrap cycle; that value is the one shown in the starting slot.
REQ-019 SHALL display each digit for exactly REFRESH_DIV-BLANK_CYC SHOW cycles per slot, giving a full left+right period of 2*REFRESH_DIV cycles.

Reset
REQ-020 SHALL, while rst=1, clear the held and display values to 8'h00, the counter to 0, the FSM to BLANK and the select to right.
REQ-021 SHALL hold seg_out=8'hFF and slot_tick=0 while rst=1, regardless of clk.
REQ-022 SHALL, after rst deasserts mid-slot, start with a full BLANK on the right digit; the first slot_tick occurs REFRESH_DIV cycles after release.

Configuration
REQ-023 SHALL, when SEG7_LZ_BLANK_EN is defined, suppress the leading zero: if the displayed value[7:4]==0, the left digit stays blank (7'b1111111) during SHOW, while slot timing and S are unchanged.
REQ-024 SHALL, when SEG7_LZ_BLANK_EN is undefined, show the left digit as '0' (0000001) when [7:4]==0.

Verification (REFRESH_DIV=8, BLANK_CYC=2 unless stated)
REQ-025 SHALL check reset: assert rst for 3 cycles -> seg_out=8'hFF and slot_tick=0; after release, the first slot_tick occurs 8 cycles later.
REQ-026 SHALL check digit display: load val_in=8'h3A -> the right slot shows 0001000_1 for 6 cycles and the left slot shows 0000110_0 for 6 cycles, each preceded by 2 cycles of 1111111.
REQ-027 SHALL check mid-slot update: load 8'h12 then 8'h34 mid-slot -> the current slot keeps its nibble of 8'h12, and the next slot shows its nibble of 8'h34.
REQ-028 SHALL check wrap-cycle valid: pulse val_valid with 8'hF0 on the wrap cycle -> the following slot uses 8'hF0.
REQ-029 SHALL check leading-zero suppression: load 8'h07 with the macro defined -> the left SHOW is 1111111_0; without the macro -> 0000001_0.
REQ-030 SHALL check the default parameters: over 24000 cycles -> exactly 4 slot_tick pulses, and S alternates on each pulse.
